dense_layer_mac: RTL

- Consumer stage placed directly downstream of the per-node distributed weight ROM bank.
- For one fully connected layer, it sweeps the shared input index 0..DEPTH-1 and broadcasts each address to all NUM_NODES weight ROMs.
- It also fetches the matching input activation and performs NUM_NODES parallel signed fixed-point multiply-accumulates.
- When the sweep ends, it delivers one rescaled, saturated and optionally ReLU-clipped output vector through a valid/ready handshake.

---
 rtl/dense_layer_mac.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dense_layer_mac.sv
// Fully connected layer MAC engine: sweeps one input index across NUM_NODES weight ROMs,
// accumulates signed fixed-point products and emits a rescaled, saturated result vector.
module dense_layer_mac #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 784,
    parameter int NUM_NODES  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FRAC_BITS  = 16,
    parameter int ACC_WIDTH  = 74,
    parameter int RELU       = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic [ADDR_WIDTH*NUM_NODES-1:0]  addr_rd,
    input  logic [WIDTH*NUM_NODES-1:0]       weight_in,
    output logic [ADDR_WIDTH-1:0]            act_addr,
    input  logic [WIDTH-1:0]                 act_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH*NUM_NODES-1:0]       out_data,
    output logic [NUM_NODES-1:0]             sat_flag
);
    localparam int PROD_WIDTH = 2 * WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]        idx;
    logic                         stage1_valid, stage2_valid;
    logic signed [PROD_WIDTH-1:0] prod      [NUM_NODES];
    logic signed [PROD_WIDTH-1:0] prod_next [NUM_NODES];
    logic signed [ACC_WIDTH-1:0]  acc       [NUM_NODES];
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]             clipped;
    logic signed [PROD_WIDTH-1:0] w_ext, a_ext;
    logic [WIDTH*NUM_NODES-1:0]   res_data;
    logic [NUM_NODES-1:0]         res_sat;
    logic                         last_idx, accept, drain_done;

    assign last_idx   = (idx == ADDR_WIDTH'(DEPTH - 1));
    assign accept     = (state == IDLE) && start;
    // The last accumulate has landed once both pipeline stages have emptied.
    assign drain_done = (state == DRAIN) && !stage1_valid && !stage2_valid;

    assign busy      = (state != IDLE);
    assign addr_rd   = {NUM_NODES{idx}};
    assign act_addr  = idx;
    // Result handshake: out_valid stays high with out_data/sat_flag stable until a rising
    // edge where out_ready is high; that edge completes the transfer and the block goes idle.
    assign out_valid = (state == OUT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_idx)   state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = OUT;
            OUT:     if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        w_ext = '0;
        a_ext = PROD_WIDTH'($signed(act_in));
        for (int i = 0; i < NUM_NODES; i++) begin
            w_ext        = PROD_WIDTH'($signed(weight_in[i*WIDTH +: WIDTH]));
            prod_next[i] = w_ext * a_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            stage1_valid <= 1'b0;
            stage2_valid <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            idx          <= (state == RUN && !last_idx) ? idx + ADDR_WIDTH'(1) : '0;
            stage1_valid <= (state == RUN);
            stage2_valid <= stage1_valid;
            for (int i = 0; i < NUM_NODES; i++) begin
                if (stage1_valid) prod[i] <= prod_next[i];
                if (accept)            acc[i] <= '0;
                else if (stage2_valid) acc[i] <= acc[i] + ACC_WIDTH'(prod[i]);
            end
        end
    end

    // Rescale by flooring shift, saturate, then optional ReLU (saturation flag survives ReLU).
    always_comb begin
        res_data = '0;
        res_sat  = '0;
        shifted  = '0;
        clipped  = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            shifted = acc[i] >>> FRAC_BITS;
            clipped = shifted[WIDTH-1:0];
            if (shifted > SAT_MAX) begin
                clipped    = {1'b0, {(WIDTH-1){1'b1}}};
                res_sat[i] = 1'b1;
            end else if (shifted < SAT_MIN) begin
                clipped    = {1'b1, {(WIDTH-1){1'b0}}};
                res_sat[i] = 1'b1;
            end
            if (RELU != 0 && clipped[WIDTH-1]) clipped = '0;
            res_data[i*WIDTH +: WIDTH] = clipped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sat_flag <= '0;
        end else if (drain_done) begin
            out_data <= res_data;
            sat_flag <= res_sat;
        end
    end
endmodule
